// File: rtl/tdc_hit_arbiter.sv
// Multi-channel TDC hit collector: per-channel pending slots, round-robin grant into a shared
// output FIFO, and an IDLE/RUN/DRAIN run-control FSM with a coarse timestamp counter.
module tdc_hit_arbiter #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CW    = 25
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic                     stop_i,
  input  logic [NCH-1:0]           en_mask_i,
  input  logic [32*NCH-1:0]        hit_word_i,
  input  logic [3*NCH-1:0]         hit_pid_i,
  output logic [63:0]              out_data_o,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [15:0]              drop_count_o,
  output logic [$clog2(DEPTH):0]   fifo_level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned RW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [AW:0] FullLevel = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e             state_q;
  logic               done_q;
  logic [CW-1:0]      coarse_q, coarse_d;
  logic [NCH-1:0]     pend_q, pend_d;
  logic [63:0]        pend_data_q [NCH];
  logic [63:0]        pend_data_d [NCH];
  logic [RW-1:0]      rr_q;
  logic [15:0]        drop_q, drop_d;
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        level_q, level_d;
  logic [63:0]        mem_q [DEPTH];

  logic               start_go, active, capture_en;
  logic               pop, push, can_push;
  logic               grant_vld;
  logic [RW-1:0]      grant_idx;
  logic [4:0]         drops;
  logic [16:0]        drop_sum;

  // Output word layout: {ch, pid, coarse, fine} packed from the top down.
  function automatic logic [63:0] pack_word(logic [3:0] ch, logic [2:0] pid,
                                            logic [CW-1:0] crs, logic [31:0] fine);
    logic [63:0] w;
    w              = '0;
    w[31:0]        = fine;
    w[32 +: CW]    = crs;
    w[32+CW +: 3]  = pid;
    w[35+CW +: 4]  = ch;
    return w;
  endfunction

  function automatic logic [RW-1:0] rr_pick(logic [RW-1:0] base, int unsigned off);
    return RW'((32'(base) + off) % NCH);
  endfunction

  assign start_go   = (state_q == StIdle) && start_i;
  assign active     = (state_q != StIdle);
  assign capture_en = (state_q == StRun);

  assign out_valid_o  = (level_q != '0);
  assign out_data_o   = out_valid_o ? mem_q[rd_ptr_q] : '0;
  assign busy_o       = active;
  assign done_o       = done_q;
  assign drop_count_o = drop_q;
  assign fifo_level_o = level_q;

  assign pop      = out_valid_o && out_ready_i;
  assign can_push = (level_q != FullLevel) || pop;
  assign push     = grant_vld;

  // Round-robin search starts one past the last granted channel.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (active && can_push) begin
      for (int unsigned i = 1; i <= NCH; i++) begin
        if (!grant_vld && pend_q[rr_pick(rr_q, i)]) begin
          grant_vld = 1'b1;
          grant_idx = rr_pick(rr_q, i);
        end
      end
    end
  end

  // A slot freed by a same-edge grant can accept a new hit without dropping it.
  always_comb begin
    pend_d = pend_q;
    for (int c = 0; c < NCH; c++) begin
      pend_data_d[c] = pend_data_q[c];
    end
    drops = '0;
    if (grant_vld) begin
      pend_d[grant_idx] = 1'b0;
    end
    if (capture_en) begin
      for (int c = 0; c < NCH; c++) begin
        if (en_mask_i[c] && (hit_word_i[32*c +: 32] != '0)) begin
          if (!pend_q[c] || (grant_vld && (32'(grant_idx) == 32'(c)))) begin
            pend_d[c]      = 1'b1;
            pend_data_d[c] = pack_word(4'(c), hit_pid_i[3*c +: 3], coarse_q,
                                       hit_word_i[32*c +: 32]);
          end else begin
            drops = drops + 5'd1;
          end
        end
      end
    end
  end

  always_comb begin
    drop_sum = {1'b0, drop_q} + {12'b0, drops};
    if (start_go) begin
      drop_d = '0;
    end else if (drop_sum[16]) begin
      drop_d = 16'hFFFF;
    end else begin
      drop_d = drop_sum[15:0];
    end
  end

  always_comb begin
    if (start_go) begin
      coarse_d = '0;
    end else if (active) begin
      coarse_d = coarse_q + 1'b1;
    end else begin
      coarse_d = coarse_q;
    end
  end

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + 1'b1;
    end else if (!push && pop) begin
      level_d = level_q - 1'b1;
    end
  end

  // Run-control FSM with registered done pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) state_q <= StRun;
        end
        StRun: begin
          if (stop_i) state_q <= StDrain;
        end
        StDrain: begin
          if ((pend_q == '0) && (level_q == '0)) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      coarse_q <= '0;
      pend_q   <= '0;
      rr_q     <= '0;
      drop_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      for (int c = 0; c < NCH; c++) begin
        pend_data_q[c] <= '0;
      end
    end else begin
      coarse_q <= coarse_d;
      pend_q   <= pend_d;
      drop_q   <= drop_d;
      level_q  <= level_d;
      for (int c = 0; c < NCH; c++) begin
        pend_data_q[c] <= pend_data_d[c];
      end
      if (grant_vld) rr_q <= grant_idx;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage is not reset; occupancy gating keeps stale words invisible.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= pend_data_q[grant_idx];
    end
  end

endmodule

// File: tb/tb_tdc_hit_arbiter.sv
// Directed bench for tdc_hit_arbiter: single hit, round-robin order, backpressure with drops,
// drain and done pulse, masking and idle hits, asynchronous reset mid-run.
module tb_tdc_hit_arbiter;

  localparam int NCH = 4;
  localparam int DEPTH = 16;
  localparam int CW = 25;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start, stop, out_ready;
  logic [NCH-1:0]        en_mask;
  logic [32*NCH-1:0]     hit_word;
  logic [3*NCH-1:0]      hit_pid;
  logic [63:0]           out_data;
  logic                  out_valid, busy, done;
  logic [15:0]           drop_count;
  logic [$clog2(DEPTH):0] fifo_level;

  int total = 0;
  int bad = 0;
  int mc = 0;
  bit counting = 1'b0;
  int c0;

  always #10 clk = ~clk;

  tdc_hit_arbiter #(.NCH(NCH), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .stop_i       (stop),
    .en_mask_i    (en_mask),
    .hit_word_i   (hit_word),
    .hit_pid_i    (hit_pid),
    .out_data_o   (out_data),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .busy_o       (busy),
    .done_o       (done),
    .drop_count_o (drop_count),
    .fifo_level_o (fifo_level)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    if (counting) mc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_hit(input int c, input logic [31:0] w, input logic [2:0] p);
    hit_word[32*c +: 32] = w;
    hit_pid[3*c +: 3]    = p;
  endtask

  task automatic clr_hits();
    hit_word = '0;
    hit_pid  = '0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    mc = 0;
    counting = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; out_ready = 1'b0;
    en_mask = '0; hit_word = '0; hit_pid = '0;
    #5;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    #10 rst_n = 1'b1;

    // Single hit on ch2 at coarse 5
    en_mask = 4'hF;
    pulse_start();
    chk("t1_busy", 64'(busy), 64'd1);
    repeat (5) tick();
    set_hit(2, 32'h0000_F000, 3'b001);
    tick();
    clr_hits();
    chk("t1_valid_early", 64'(out_valid), 64'd0);
    tick();
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_data", out_data, {4'd2, 3'b001, 25'd5, 32'h0000_F000});
    chk("t1_level1", 64'(fifo_level), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("t1_level0", 64'(fifo_level), 64'd0);
    chk("t1_empty", 64'(out_valid), 64'd0);

    // Round-robin: park pointer on ch3, then two full bursts emerge 0,1,2,3
    set_hit(3, 32'h1, 3'b100);
    tick();
    clr_hits();
    tick();
    chk("t2_ch3", 64'(out_data[63:60]), 64'd3);
    tick();
    chk("t2_ch3_gone", 64'(out_valid), 64'd0);
    for (int b = 0; b < 2; b++) begin
      for (int c = 0; c < NCH; c++) set_hit(c, 32'h11 * (c + 1), 3'(c + 1));
      tick();
      clr_hits();
      for (int k = 0; k < NCH; k++) begin
        tick();
        chk($sformatf("t2_b%0d_ch%0d", b, k), 64'(out_data[63:60]), 64'(k));
        chk($sformatf("t2_b%0d_pid%0d", b, k), 64'(out_data[59:57]), 64'(k + 1));
      end
      tick();
      chk($sformatf("t2_b%0d_empty", b), 64'(out_valid), 64'd0);
    end
    chk("t2_drop", 64'(drop_count), 64'd0);

    // Backpressure: 20 consecutive ch0 hits into a 16-deep FIFO
    out_ready = 1'b0;
    c0 = mc;
    set_hit(0, 32'hA5A5_0001, 3'b010);
    repeat (20) tick();
    clr_hits();
    chk("t3_level_full", 64'(fifo_level), 64'd16);
    chk("t3_drop", 64'(drop_count), 64'd3);
    chk("t3_head_coarse", 64'(out_data[56:32]), 64'(25'(c0)));
    out_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("t3_coarse%0d", k), 64'(out_data[56:32]), 64'(25'(c0 + k)));
      if (k == 1) chk("t3_level_refill", 64'(fifo_level), 64'd16);
    end
    tick();
    chk("t3_level_end", 64'(fifo_level), 64'd0);
    chk("t3_valid_end", 64'(out_valid), 64'd0);

    // Drain: 5 queued words, hits in DRAIN ignored, single done pulse
    out_ready = 1'b0;
    set_hit(0, 32'h0000_0100, 3'b001);
    repeat (5) tick();
    clr_hits();
    tick();
    chk("t4_level5", 64'(fifo_level), 64'd5);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t4_busy", 64'(busy), 64'd1);
    for (int c = 0; c < NCH; c++) set_hit(c, 32'hFFFF_FFFF, 3'b111);
    repeat (2) tick();
    clr_hits();
    chk("t4_level_hold", 64'(fifo_level), 64'd5);
    chk("t4_drop_hold", 64'(drop_count), 64'd3);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("t4_level%0d", k), 64'(fifo_level), 64'(4 - k));
      chk($sformatf("t4_nodone%0d", k), 64'(done), 64'd0);
    end
    tick();
    chk("t4_done", 64'(done), 64'd1);
    chk("t4_idle", 64'(busy), 64'd0);
    tick();
    chk("t4_done_once", 64'(done), 64'd0);
    counting = 1'b0;

    // Idle hits and masked channel
    set_hit(0, 32'h1, 3'b001);
    repeat (3) tick();
    clr_hits();
    chk("t5_idle_valid", 64'(out_valid), 64'd0);
    chk("t5_idle_level", 64'(fifo_level), 64'd0);
    chk("t5_idle_drop", 64'(drop_count), 64'd3);
    en_mask = 4'b1011;
    pulse_start();
    chk("t5_drop_clear", 64'(drop_count), 64'd0);
    set_hit(2, 32'h8000_0000, 3'b100);
    repeat (4) tick();
    clr_hits();
    chk("t5_mask_valid", 64'(out_valid), 64'd0);
    chk("t5_mask_level", 64'(fifo_level), 64'd0);
    chk("t5_mask_drop", 64'(drop_count), 64'd0);

    // Async reset mid-run with 8 words queued
    en_mask = 4'hF;
    out_ready = 1'b0;
    set_hit(1, 32'h0000_00FF, 3'b010);
    repeat (8) tick();
    clr_hits();
    tick();
    chk("t6_level8", 64'(fifo_level), 64'd8);
    #4 rst_n = 1'b0;
    #1;
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_level", 64'(fifo_level), 64'd0);
    chk("t6_drop", 64'(drop_count), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_data", out_data, 64'd0);
    #5 rst_n = 1'b1;
    tick();
    chk("t6_post_level", 64'(fifo_level), 64'd0);
    chk("t6_post_busy", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
